// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller in front of a registered-read RAM.
// Define CACHE_STATS_EN to build the saturating read-hit/read-miss counters; otherwise they are tied to 0.
module cache_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int INDEX_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic                  cpu_req_we,
  input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
  input  logic [DATA_WIDTH-1:0] cpu_req_wdata,
  output logic                  cpu_resp_valid,
  output logic [DATA_WIDTH-1:0] cpu_resp_data,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_w_data,
  input  logic [DATA_WIDTH-1:0] mem_r_data,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH;

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_FILL, WR} state_t;

  state_t                  state_q, state_d;
  logic                    ready_q, ready_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0]   resp_data_q, resp_data_d;
  logic                    mem_wr_en_q, mem_wr_en_d;
  logic                    mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_w_data_q, mem_w_data_d;
  logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
  logic [LINES-1:0]        valid_q, valid_d;

  logic [TAG_W-1:0]        tag_mem  [LINES];
  logic [DATA_WIDTH-1:0]   data_mem [LINES];

  logic [INDEX_WIDTH-1:0]  req_idx, fill_idx, arr_idx;
  logic [TAG_W-1:0]        req_tag, arr_tag;
  logic [DATA_WIDTH-1:0]   arr_data;
  logic                    arr_we;
  logic                    accept;
  logic                    lookup_hit;

  assign req_idx    = cpu_req_addr[INDEX_WIDTH-1:0];
  assign req_tag    = cpu_req_addr[ADDR_WIDTH-1:INDEX_WIDTH];
  assign fill_idx   = req_addr_q[INDEX_WIDTH-1:0];
  assign accept     = cpu_req_valid && ready_q;
  assign lookup_hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    mem_wr_en_d  = 1'b0;
    mem_rd_en_d  = 1'b0;
    mem_addr_d   = '0;
    mem_w_data_d = '0;
    req_addr_d   = req_addr_q;
    valid_d      = valid_q;
    arr_we       = 1'b0;
    arr_idx      = req_idx;
    arr_tag      = req_tag;
    arr_data     = cpu_req_wdata;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          req_addr_d = cpu_req_addr;
          if (cpu_req_we) begin
            // Write hits refresh the line; the tag written back equals the stored one.
            state_d      = WR;
            mem_wr_en_d  = 1'b1;
            mem_addr_d   = cpu_req_addr;
            mem_w_data_d = cpu_req_wdata;
            arr_we       = lookup_hit;
          end else if (lookup_hit) begin
            resp_valid_d = 1'b1;
            resp_data_d  = data_mem[req_idx];
          end else begin
            state_d     = RD_REQ;
            mem_rd_en_d = 1'b1;
            mem_addr_d  = cpu_req_addr;
          end
        end
      end
      RD_REQ: state_d = RD_FILL;
      RD_FILL: begin
        state_d           = IDLE;
        resp_valid_d      = 1'b1;
        resp_data_d       = mem_r_data;
        arr_we            = 1'b1;
        arr_idx           = fill_idx;
        arr_tag           = req_addr_q[ADDR_WIDTH-1:INDEX_WIDTH];
        arr_data          = mem_r_data;
        valid_d[fill_idx] = 1'b1;
      end
      WR: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      mem_wr_en_q  <= 1'b0;
      mem_rd_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_w_data_q <= '0;
      req_addr_q   <= '0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      mem_wr_en_q  <= mem_wr_en_d;
      mem_rd_en_q  <= mem_rd_en_d;
      mem_addr_q   <= mem_addr_d;
      mem_w_data_q <= mem_w_data_d;
      req_addr_q   <= req_addr_d;
      valid_q      <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (arr_we) begin
      tag_mem[arr_idx]  <= arr_tag;
      data_mem[arr_idx] <= arr_data;
    end
  end

  assign cpu_req_ready  = ready_q;
  assign cpu_resp_valid = resp_valid_q;
  assign cpu_resp_data  = resp_data_q;
  assign mem_wr_en      = mem_wr_en_q;
  assign mem_rd_en      = mem_rd_en_q;
  assign mem_addr       = mem_addr_q;
  assign mem_w_data     = mem_w_data_q;

`ifdef CACHE_STATS_EN
  logic        stat_hit, stat_miss;
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  assign stat_hit  = accept && !cpu_req_we && lookup_hit;
  assign stat_miss = accept && !cpu_req_we && !lookup_hit;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (stat_hit && (hit_count_q != 32'hFFFF_FFFF))
      hit_count_d = hit_count_q + 32'd1;
    if (stat_miss && (miss_count_q != 32'hFFFF_FFFF))
      miss_count_d = miss_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed testbench for cache_ctrl: a registered-read RAM model plus a queue of expected read data.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req_valid;
  logic        cpu_req_ready;
  logic        cpu_req_we;
  logic [15:0] cpu_req_addr;
  logic [31:0] cpu_req_wdata;
  logic        cpu_resp_valid;
  logic [31:0] cpu_resp_data;
  logic        mem_wr_en;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [31:0] mem_w_data;
  logic [31:0] mem_r_data = '0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  logic [31:0] ram [0:65535];
  logic [31:0] rd_q [$];
  int n_asserts = 0;
  int n_fail    = 0;
  int exp_hits  = 0;
  int exp_misses = 0;
  logic [31:0] last_resp = '0;

  cache_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_we(cpu_req_we), .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_data(cpu_resp_data),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_w_data(mem_w_data), .mem_r_data(mem_r_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr_en) ram[mem_addr] <= mem_w_data;
    if (mem_rd_en) mem_r_data <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_counts(input string tag);
    logic [31:0] eh, em;
`ifdef CACHE_STATS_EN
    eh = 32'(exp_hits);
    em = 32'(exp_misses);
`else
    eh = '0;
    em = '0;
`endif
    check({tag, "_hits"}, hit_count, eh);
    check({tag, "_misses"}, miss_count, em);
  endtask

  // Called at a falling edge with the controller idle; returns at the falling edge where the response is seen.
  task automatic issue(input bit we, input logic [15:0] addr, input logic [31:0] wdata,
                       input bit exp_hit, input logic [31:0] exp_data, input string tag);
    int lat, exp_lat, rd_pulses, wr_pulses;
    bit bus_ok;
    logic [31:0] d;
    check({tag, "_ready"}, 32'(cpu_req_ready), 32'd1);
    cpu_req_valid = 1'b1;
    cpu_req_we    = we;
    cpu_req_addr  = addr;
    cpu_req_wdata = wdata;
    if (!we) begin
      rd_q.push_back(exp_data);
      if (exp_hit) exp_hits++; else exp_misses++;
    end
    exp_lat = we ? 2 : (exp_hit ? 1 : 3);
    @(posedge clk);
    @(negedge clk);
    cpu_req_valid = 1'b0;
    lat = 1; rd_pulses = 0; wr_pulses = 0; bus_ok = 1'b1;
    while (1) begin
      if (mem_rd_en) begin
        rd_pulses++;
        if (mem_addr !== addr) bus_ok = 1'b0;
      end
      if (mem_wr_en) begin
        wr_pulses++;
        if (mem_addr !== addr || mem_w_data !== wdata) bus_ok = 1'b0;
      end
      if (mem_rd_en && mem_wr_en) bus_ok = 1'b0;
      if (!mem_rd_en && !mem_wr_en && (mem_addr !== 16'h0 || mem_w_data !== 32'h0)) bus_ok = 1'b0;
      if (cpu_resp_valid === 1'b1 || lat >= 10) break;
      @(negedge clk);
      lat++;
    end
    if (cpu_resp_valid !== 1'b1) lat = 99;
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    if (!we) begin
      d = rd_q.pop_front();
      check({tag, "_rdata"}, cpu_resp_data, d);
      last_resp = d;
    end else begin
      check({tag, "_hold"}, cpu_resp_data, last_resp);
    end
    check({tag, "_rd_pulses"}, 32'(rd_pulses), 32'((!we && !exp_hit) ? 1 : 0));
    check({tag, "_wr_pulses"}, 32'(wr_pulses), 32'(we ? 1 : 0));
    check({tag, "_bus"}, 32'(bus_ok), 32'd1);
    check_counts(tag);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    bit resp_seen;
    ram[16'h0010] = 32'hDEADBEEF;
    ram[16'h0011] = 32'h11111111;
    ram[16'h0111] = 32'h22222222;
    rst_n = 1'b0;
    cpu_req_valid = 1'b0;
    cpu_req_we = 1'b0;
    cpu_req_addr = '0;
    cpu_req_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(cpu_req_ready), 32'd1);
    check("rst_resp_valid", 32'(cpu_resp_valid), 32'd0);
    check("rst_resp_data", cpu_resp_data, 32'd0);
    check("rst_enables", {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_w_data", mem_w_data, 32'd0);
    check_counts("rst");
    rst_n = 1'b1;
    @(negedge clk);

    issue(1'b0, 16'h0010, 32'h0, 1'b0, 32'hDEADBEEF, "rd_miss_10");
    issue(1'b0, 16'h0010, 32'h0, 1'b1, 32'hDEADBEEF, "rd_hit_10");
    issue(1'b1, 16'h0010, 32'h12345678, 1'b1, 32'h0, "wr_hit_10");
    issue(1'b0, 16'h0010, 32'h0, 1'b1, 32'h12345678, "rd_after_wr_10");
    issue(1'b1, 16'h0020, 32'hA5A5A5A5, 1'b0, 32'h0, "wr_miss_20");
    issue(1'b0, 16'h0020, 32'h0, 1'b0, 32'hA5A5A5A5, "rd_miss_20");

    // Two hits accepted on consecutive edges
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 16'h0020;
    rd_q.push_back(32'hA5A5A5A5); exp_hits++;
    @(posedge clk); @(negedge clk);
    check("b2b_ready", 32'(cpu_req_ready), 32'd1);
    check("b2b_valid1", 32'(cpu_resp_valid), 32'd1);
    d = rd_q.pop_front();
    check("b2b_data1", cpu_resp_data, d);
    rd_q.push_back(32'hA5A5A5A5); exp_hits++;
    @(posedge clk); @(negedge clk);
    cpu_req_valid = 1'b0;
    check("b2b_valid2", 32'(cpu_resp_valid), 32'd1);
    d = rd_q.pop_front();
    check("b2b_data2", cpu_resp_data, d);
    check("b2b_no_rd", 32'(mem_rd_en), 32'd0);
    check_counts("b2b");
    last_resp = d;

    issue(1'b0, 16'h0011, 32'h0, 1'b0, 32'h11111111, "conf_rd_11");
    issue(1'b0, 16'h0111, 32'h0, 1'b0, 32'h22222222, "conf_rd_111");
    issue(1'b0, 16'h0011, 32'h0, 1'b0, 32'h11111111, "conf_rd_11_again");

    // Reset while the miss for 0x0030 sits in RD_REQ
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 16'h0030;
    @(posedge clk); @(negedge clk);
    cpu_req_valid = 1'b0;
    check("abort_rd_en_before", 32'(mem_rd_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_rd_en_async", 32'(mem_rd_en), 32'd0);
    check("abort_ready", 32'(cpu_req_ready), 32'd1);
    resp_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (cpu_resp_valid !== 1'b0) resp_seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (cpu_resp_valid !== 1'b0) resp_seen = 1'b1;
    end
    check("abort_no_resp", 32'(resp_seen), 32'd0);
    exp_hits = 0;
    exp_misses = 0;
    last_resp = '0;
    check_counts("abort");
    issue(1'b0, 16'h0010, 32'h0, 1'b0, 32'h12345678, "post_rst_rd_10");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Direct-mapped, write-through, no-write-allocate cache controller between a single CPU-side requester and the 32-bit x 64K backing RAM. It holds tags, valid bits and data for 2^INDEX_WIDTH one-word lines. Hits are served locally. It sequences the RAM's `wr_en`/`rd_en`/`addr`/`w_data`/`r_data` port for read misses (line fill) and for every write (write-through).

## Interface
- `DATA_WIDTH`, 32, word width; matches the RAM.
- `ADDR_WIDTH`, 16, word address width; matches the RAM.
- `INDEX_WIDTH`, 4, line index bits. There are 2^INDEX_WIDTH lines, and the tag is `ADDR_WIDTH-INDEX_WIDTH` bits.
- Ports:
  - `clk` in 1: single clock, rising edge.
  - `rst_n` in 1: asynchronous, active-low reset.
  - `cpu_req_valid` in 1: request present.
  - `cpu_req_ready` out 1: controller can accept a request.
  - `cpu_req_we` in 1: 1 = write, 0 = read.
  - `cpu_req_addr` in ADDR_WIDTH: word address.
  - `cpu_req_wdata` in DATA_WIDTH: write data.
  - `cpu_resp_valid` out 1: one-cycle completion pulse.
  - `cpu_resp_data` out DATA_WIDTH: read data, valid with the pulse.
  - `mem_wr_en` out 1: RAM write enable.
  - `mem_rd_en` out 1: RAM read enable.
  - `mem_addr` out ADDR_WIDTH: RAM address.
  - `mem_w_data` out DATA_WIDTH: RAM write data.
  - `mem_r_data` in DATA_WIDTH: RAM registered read data, available the cycle after `mem_rd_en`.
  - `hit_count` out 32: read-hit count (see Configuration).
  - `miss_count` out 32: read-miss count (see Configuration).

## Operation
- Address split:
  - index = `cpu_req_addr[INDEX_WIDTH-1:0]`
  - tag = upper bits.
  - Hit = line valid and stored tag equal.
- Accept occurs on a rising edge with `cpu_req_valid && cpu_req_ready`.
  - On accept, addr, we and wdata are latched.
  - `cpu_req_ready` = 1 only in IDLE. Requests are ignored while it is 0, and the requester must hold them.
- FSM states:
  - IDLE.
  - RD_REQ: `mem_rd_en`=1, `mem_addr`=latched addr.
  - RD_FILL: line written from `mem_r_data`, valid set, tag stored.
  - WR: `mem_wr_en`=1, `mem_addr`/`mem_w_data` = latched addr/wdata.
- Transitions:
  - IDLE → IDLE on a read hit.
  - IDLE → RD_REQ on a read miss.
  - IDLE → WR on any write.
  - RD_REQ → RD_FILL.
  - RD_FILL → IDLE.
  - WR → IDLE.
- Read hit: at the accept edge, `cpu_resp_data` gets the line data and `cpu_resp_valid` is set.
- Read miss: at the RD_FILL exit edge, `cpu_resp_data` gets `mem_r_data` and `cpu_resp_valid` is set.
- Write hit: the line data is updated at the accept edge, and the tag/valid bits are unchanged.
- Write miss: the cache is unchanged (no allocate).
- Write response: `cpu_resp_valid` is set at the WR exit edge, and `cpu_resp_data` holds its previous value.
- `mem_wr_en` and `mem_rd_en` are never both 1, and both are 0 in IDLE. `mem_addr` and `mem_w_data` are 0 when no enable is asserted.
- There is no response back-pressure: `cpu_resp_valid` is a single-cycle pulse and the requester must capture it.
- A new request may be accepted in the same cycle `cpu_resp_valid` is high, because the FSM is in IDLE.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - All valid bits are cleared and the FSM returns to IDLE.
  - `cpu_req_ready`=1, `cpu_resp_valid`=0, `cpu_resp_data`=0.
  - `mem_wr_en`, `mem_rd_en`, `mem_addr`, `mem_w_data` = 0.
  - Counters are cleared.
  - Tag and data arrays need no reset.
- Latency from the accept edge to the `cpu_resp_valid` high cycle:
  - read hit: 1 cycle;
  - read miss: 3 cycles;
  - write: 2 cycles.
- Back-to-back read hits sustain one request per cycle.
- Reset mid-miss or mid-write: enables drop immediately, and no line is allocated or response issued. The RAM write may or may not have completed.
- Index wrap: addresses differing only in tag conflict, and a fill overwrites the line.
- A read after a write to the same address in consecutive accepts returns the new data:
  - on a hit, via the cache;
  - on a miss, via the RAM, since the write completes before IDLE.

## Configuration
- `CACHE_STATS_EN` defined:
  - `hit_count` increments on each read-hit accept.
  - `miss_count` increments on each read-miss accept.
  - Both counters are 32-bit, saturate at 0xFFFFFFFF, and clear on reset.
  - Writes are not counted.
- Not defined: `hit_count` and `miss_count` are tied to 0 and no counter logic is synthesized.

## Test plan
- Reset, then read 0x0010 with RAM[0x0010]=0xDEADBEEF:
  - `mem_rd_en` pulses one cycle with addr 0x0010;
  - `cpu_resp_valid` appears 3 cycles after accept with data 0xDEADBEEF;
  - miss_count=1.
- Re-read 0x0010 immediately: `cpu_resp_valid` appears 1 cycle after accept with data 0xDEADBEEF, no `mem_rd_en`, hit_count=1.
- Write 0x0010 ← 0x12345678:
  - `mem_wr_en` pulses one cycle (addr 0x0010, data 0x12345678);
  - ack appears 2 cycles after accept;
  - a following read of 0x0010 hits and returns 0x12345678.
- Write miss 0x0020 ← 0xA5A5A5A5, then read 0x0020: the RAM is written, the read misses, and the fill returns 0xA5A5A5A5.
- Conflict: read 0x0011 (fill), read 0x0111 (same index, miss, refill), read 0x0011 again → miss, miss_count increments 3 times.
- Assert `rst_n`=0 during RD_REQ of a miss:
  - `mem_rd_en` drops asynchronously and no `cpu_resp_valid` is issued;
  - after release, a read of the previously cached 0x0010 misses because the valid bits are cleared.
